// File: rtl/led_status_pkg.sv
// Shared types for the front-panel LED driver: per-channel mode encoding,
// breath direction, and the PHY link-state to mode mapping.
package led_status_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        LED_OFF      = 3'd0,
        LED_ON       = 3'd1,
        LED_SLOW     = 3'd2,
        LED_FAST     = 3'd3,
        LED_BREATH   = 3'd4,
        LED_ON_ACT   = 3'd5,
        LED_ACT_ONLY = 3'd6,
        LED_RSVD     = 3'd7
    } led_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } breath_dir_t;

    // Link state encoding from the PHY: none / 100M / 1G / 10M
    function automatic led_mode_t link_st_to_mode(input logic [1:0] link_st);
        led_mode_t mode;
        case (link_st)
            2'b00:   mode = LED_OFF;
            2'b01:   mode = LED_BREATH;
            2'b10:   mode = LED_ON;
            default: mode = LED_SLOW;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/breath_pwm_gen.sv
// Shared breath PWM: duty ramps between PWM_MIN and PWM_MAX, one step every
// BREATH_DIV PWM periods; breath_c is lit while pwm_cnt < duty.
module breath_pwm_gen
    import led_status_pkg::*;
#(
    parameter int unsigned PWM_FULL   = 2000,
    parameter int unsigned PWM_MIN    = 2,
    parameter int unsigned PWM_MAX    = 2000,
    parameter int unsigned BREATH_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_reset_n,
    output logic breath_c
);

    localparam int unsigned PWM_W = $clog2(PWM_FULL + 1);
    localparam int unsigned DIV_W = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;

    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] duty_nxt;
    logic [DIV_W-1:0] div_cnt;
    breath_dir_t      dir;
    breath_dir_t      dir_nxt;
    logic             pwm_wrap_c;
    logic             div_last_c;
    logic             step_c;

    assign pwm_wrap_c = (pwm_cnt == PWM_W'(PWM_FULL - 1));
    assign div_last_c = (div_cnt == DIV_W'(BREATH_DIV - 1));
    assign step_c     = pwm_wrap_c && div_last_c;

    // PWM period counter and step divider
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_wrap_c ? '0 : pwm_cnt + PWM_W'(1);
            if (pwm_wrap_c) begin
                div_cnt <= div_last_c ? '0 : div_cnt + DIV_W'(1);
            end
        end
    end

    // Direction/duty state register
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            dir  <= DIR_UP;
            duty <= PWM_W'(PWM_MIN);
        end else begin
            dir  <= dir_nxt;
            duty <= duty_nxt;
        end
    end

    // Turn around at the end stops so duty stays inside [PWM_MIN, PWM_MAX]
    always_comb begin
        dir_nxt  = dir;
        duty_nxt = duty;
        if (step_c) begin
            case (dir)
                DIR_UP: begin
                    if (duty >= PWM_W'(PWM_MAX)) begin
                        dir_nxt  = DIR_DOWN;
                        duty_nxt = duty - PWM_W'(1);
                    end else begin
                        duty_nxt = duty + PWM_W'(1);
                    end
                end
                DIR_DOWN: begin
                    if (duty <= PWM_W'(PWM_MIN)) begin
                        dir_nxt  = DIR_UP;
                        duty_nxt = duty + PWM_W'(1);
                    end else begin
                        duty_nxt = duty - PWM_W'(1);
                    end
                end
                default: begin
                    dir_nxt  = DIR_UP;
                    duty_nxt = PWM_W'(PWM_MIN);
                end
            endcase
        end
    end

    assign breath_c = (pwm_cnt < duty);

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver: shared blink counter and breath PWM,
// per-channel activity stretch and mode decode, registered LED drive.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int unsigned CH_COUNT       = 8,
    parameter int unsigned SLOW_BIT       = 25,
    parameter int unsigned FAST_BIT       = 22,
    parameter int unsigned PWM_FULL       = 2000,
    parameter int unsigned PWM_MIN        = 2,
    parameter int unsigned PWM_MAX        = 2000,
    parameter int unsigned BREATH_DIV     = 4,
    parameter int unsigned ACT_STRETCH    = 5_000_000,
    parameter int unsigned LED_ACTIVE_LOW = 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_reset_n,
    input  logic [MODE_W*CH_COUNT-1:0]   ch_mode,
    input  logic [CH_COUNT-1:0]          ch_activity,
    input  logic                         lamp_test,
    output logic                         slow_phase,
    output logic                         fast_phase,
    output logic [CH_COUNT-1:0]          led_out
);

    localparam int unsigned BLINK_W = SLOW_BIT + 1;
    localparam int unsigned STR_W   = $clog2(ACT_STRETCH + 1);
    localparam logic        POL     = (LED_ACTIVE_LOW != 0);
    localparam logic [CH_COUNT-1:0] DARK = {CH_COUNT{POL}};

    logic [BLINK_W-1:0]  blink_cnt;
    logic                breath_c;
    logic [CH_COUNT-1:0] act_c;
    logic [CH_COUNT-1:0] lit_c;

    breath_pwm_gen #(
        .PWM_FULL   (PWM_FULL),
        .PWM_MIN    (PWM_MIN),
        .PWM_MAX    (PWM_MAX),
        .BREATH_DIV (BREATH_DIV)
    ) u_breath (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .breath_c    (breath_c)
    );

    for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
        logic [STR_W-1:0] stretch;
        led_mode_t        mode;
        logic             lit_ch;

        // Reload on activity so back-to-back strobes never leave a gap
        always_ff @(posedge sys_clk or negedge sys_reset_n) begin
            if (!sys_reset_n) begin
                stretch <= '0;
            end else if (ch_activity[i]) begin
                stretch <= STR_W'(ACT_STRETCH);
            end else if (stretch != '0) begin
                stretch <= stretch - STR_W'(1);
            end
        end

        assign act_c[i] = (stretch != '0);
        assign mode     = led_mode_t'(ch_mode[MODE_W*i +: MODE_W]);

        always_comb begin
            lit_ch = 1'b0;
            case (mode)
                LED_OFF:      lit_ch = 1'b0;
                LED_ON:       lit_ch = 1'b1;
                LED_SLOW:     lit_ch = blink_cnt[SLOW_BIT];
                LED_FAST:     lit_ch = blink_cnt[FAST_BIT];
                LED_BREATH:   lit_ch = breath_c;
                LED_ON_ACT:   lit_ch = act_c[i] ? blink_cnt[FAST_BIT] : 1'b1;
                LED_ACT_ONLY: lit_ch = act_c[i];
                default:      lit_ch = 1'b0;
            endcase
            if (lamp_test) begin
                lit_ch = 1'b1;
            end
        end

        assign lit_c[i] = lit_ch;
    end

    // Phases and LEDs sample the same blink_cnt value, so they stay aligned
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            blink_cnt  <= '0;
            slow_phase <= 1'b0;
            fast_phase <= 1'b0;
            led_out    <= DARK;
        end else begin
            blink_cnt  <= blink_cnt + BLINK_W'(1);
            slow_phase <= blink_cnt[SLOW_BIT];
            fast_phase <= blink_cnt[FAST_BIT];
            led_out    <= lit_c ^ DARK;
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with small blink/PWM/stretch parameters.
module tb_led_status_ctrl;
    import led_status_pkg::*;

    localparam int unsigned CH = 4;

    logic          sys_clk = 1'b0;
    logic          sys_reset_n;
    logic [3*CH-1:0] ch_mode;
    logic [CH-1:0] ch_activity;
    logic          lamp_test;
    logic          slow_phase;
    logic          fast_phase;
    logic [CH-1:0] led_out;

    int checks = 0;
    int errors = 0;
    int cyc;

    led_status_ctrl #(
        .CH_COUNT       (CH),
        .SLOW_BIT       (4),
        .FAST_BIT       (2),
        .PWM_FULL       (8),
        .PWM_MIN        (1),
        .PWM_MAX        (7),
        .BREATH_DIV     (1),
        .ACT_STRETCH    (10),
        .LED_ACTIVE_LOW (1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .ch_mode     (ch_mode),
        .ch_activity (ch_activity),
        .lamp_test   (lamp_test),
        .slow_phase  (slow_phase),
        .fast_phase  (fast_phase),
        .led_out     (led_out)
    );

    always #5 sys_clk = ~sys_clk;

    // Clock edges since reset release; blink counter value before edge n is n-1
    always @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) cyc <= 0;
        else              cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // ch3 ACT_ONLY: pulse at relative edge 0, optional second pulse, lit window 1..lit_last
    task automatic act_scenario(input string tag, input int second_at, input int lit_last);
        for (int j = 0; j <= lit_last + 3; j++) begin
            ch_activity[3] = (j == 0) || (j == second_at);
            step();
            check_eq(tag, 32'(led_out[3]), 32'(!((j >= 1) && (j <= lit_last))));
        end
        ch_activity[3] = 1'b0;
    endtask

    initial begin
        int b;
        int p;
        int d;
        int lit_cnt;
        logic exp_lit;

        sys_reset_n = 1'b0;
        ch_mode     = {4{3'(LED_ON)}};
        ch_activity = '0;
        lamp_test   = 1'b0;

        repeat (3) @(negedge sys_clk);
        check_eq("rst_led", 32'(led_out), 32'h0000_000f);
        check_eq("rst_slow", 32'(slow_phase), 32'h0);
        check_eq("rst_fast", 32'(fast_phase), 32'h0);

        sys_reset_n = 1'b1;
        step();
        check_eq("rel_on", 32'(led_out), 32'h0);

        ch_mode = {3'(LED_ACT_ONLY), 3'(LED_BREATH), 3'(LED_FAST), 3'(LED_SLOW)};
        lit_cnt = 0;
        for (int k = 2; k <= 120; k++) begin
            step();
            b = k - 1;
            check_eq("slow_ph", 32'(slow_phase), 32'(b[4]));
            check_eq("fast_ph", 32'(fast_phase), 32'(b[2]));
            check_eq("led_slow", 32'(led_out[0]), 32'(!b[4]));
            check_eq("led_fast", 32'(led_out[1]), 32'(!b[2]));
            check_eq("led_idle", 32'(led_out[3]), 32'h1);
            if (!led_out[2]) lit_cnt++;
            if (k % 8 == 0) begin
                p = k / 8 - 1;
                if (p >= 1) begin
                    d = p % 12;
                    check_eq("breath_duty", 32'(lit_cnt), 32'((d <= 6) ? d + 1 : 13 - d));
                end
                lit_cnt = 0;
            end
        end

        act_scenario("act_single", -1, 10);
        act_scenario("act_extend", 9, 19);
        act_scenario("act_reload1", 10, 20);

        // ch0 ON_ACT with activity held, then switched to ACT_ONLY mid-stretch
        for (int j = 0; j <= 35; j++) begin
            if (j == 0)  ch_mode[2:0] = 3'(LED_ON_ACT);
            if (j == 25) ch_mode[2:0] = 3'(LED_ACT_ONLY);
            ch_activity[0] = (j < 20);
            step();
            b = cyc - 1;
            if (j < 25) exp_lit = ((j >= 1) && (j <= 29)) ? b[2] : 1'b1;
            else        exp_lit = (j <= 29);
            check_eq("on_act", 32'(led_out[0]), 32'(!exp_lit));
        end

        ch_mode = {4{3'(LED_OFF)}};
        step();
        check_eq("all_off", 32'(led_out), 32'h0000_000f);
        lamp_test = 1'b1;
        step();
        check_eq("lamp", 32'(led_out), 32'h0);

        #2;
        sys_reset_n = 1'b0;
        #1;
        check_eq("async_rst_led", 32'(led_out), 32'h0000_000f);
        check_eq("async_rst_slow", 32'(slow_phase), 32'h0);
        check_eq("async_rst_fast", 32'(fast_phase), 32'h0);

        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
Multi-channel status-LED driver that generalises the board-level LED logic (fixed flash counter, one breath PWM, hard-wired link-speed mux) into one parametrised block. Each channel takes a per-channel 3-bit mode plus an activity strobe. One free-running blink counter and one breath PWM are shared by all channels. Sits in the board top, driving the front-panel LEDs from PHY link state, SFP tunnel state and traffic activity.

Parameters:
CH_COUNT, 8, number of LED channels (1..32)
SLOW_BIT, 25, blink-counter bit used as slow-blink phase (2^25 cycles per half period)
FAST_BIT, 22, blink-counter bit used as fast-blink phase; must be < SLOW_BIT
PWM_FULL, 2000, breath PWM period in cycles
PWM_MIN, 2, minimum breath duty (cycles lit per PWM period)
PWM_MAX, 2000, maximum breath duty; PWM_MIN < PWM_MAX <= PWM_FULL
BREATH_DIV, 4, PWM periods per duty step
ACT_STRETCH, 5_000_000, activity pulse-stretch length in cycles
LED_ACTIVE_LOW, 1, 1 = led_out 0 lights the LED

Ports:
sys_clk  in  1  single clock for all logic
sys_reset_n  in  1  asynchronous, active-low reset
ch_mode  in  3*CH_COUNT  per-channel mode; bits [3i+2:3i] belong to channel i
ch_activity  in  CH_COUNT  per-channel activity level/strobe, synchronous to sys_clk
lamp_test  in  1  when 1, forces every channel lit
slow_phase  out  1  registered slow-blink phase, exported for reuse
fast_phase  out  1  registered fast-blink phase
led_out  out  CH_COUNT  registered LED drive, polarity set by LED_ACTIVE_LOW

Behaviour:
- Reset (async assert, sync release):
  - blink_cnt = 0, pwm_cnt = 0, duty = PWM_MIN, dir = up, div_cnt = 0.
  - All stretch counters = 0.
  - slow_phase = fast_phase = 0.
  - led_out = {CH_COUNT{LED_ACTIVE_LOW}} (all dark).
- blink_cnt: SLOW_BIT+1 bits, increments every cycle, wraps naturally. slow_phase <= blink_cnt[SLOW_BIT]; fast_phase <= blink_cnt[FAST_BIT].
- Breath PWM:
  - pwm_cnt counts 0..PWM_FULL-1 and wraps.
  - At each wrap, div_cnt increments. When div_cnt == BREATH_DIV-1 it clears and duty steps ±1.
  - Direction: at duty == PWM_MAX the next step goes down; at duty == PWM_MIN the next step goes up. Duty never leaves [PWM_MIN, PWM_MAX].
  - breath = (pwm_cnt < duty).
- Activity stretch, per channel:
  - ch_activity[i] == 1 loads stretch[i] = ACT_STRETCH. Held high, it reloads every cycle.
  - Otherwise stretch[i] decrements while nonzero and saturates at 0.
  - act[i] = (stretch[i] != 0). Counter width is $clog2(ACT_STRETCH+1).
- Mode decode, lit[i]:
  - 0 OFF: 0
  - 1 ON: 1
  - 2 SLOW: slow phase
  - 3 FAST: fast phase
  - 4 BREATH: breath
  - 5 ON_ACT: 1 when !act; fast phase when act
  - 6 ACT_ONLY: act
  - 7 reserved: 0
- lamp_test == 1 forces lit = all ones and overrides every mode.
- Output: led_out[i] <= lit[i] ^ LED_ACTIVE_LOW.
- Latency: a mode or lamp_test change appears on led_out exactly 1 cycle later. An activity pulse makes act visible 1 cycle after the pulse, so led_out changes 2 cycles after it.
- Blink phases: lit uses the same-cycle blink_cnt bits, so led_out and the slow_phase/fast_phase ports are aligned.
- Boundary cases:
  - Activity on the cycle stretch reaches 1: reload wins, no gap.
  - Mode change mid-stretch: the stretch keeps counting; only the decode changes.
  - Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package led_status_pkg:
  - typedef enum logic [2:0] led_mode_t: LED_OFF, LED_ON, LED_SLOW, LED_FAST, LED_BREATH, LED_ON_ACT, LED_ACT_ONLY, LED_RSVD.
  - Helper function link_st_to_mode mapping 2'b00/01/10/11 (none/100M/1G/10M) to OFF/BREATH/ON/SLOW.
- One sub-module, breath_pwm_gen: owns pwm_cnt, div_cnt, duty and dir, and outputs breath. It is instantiated once and shared by all channels.

Test Plan:
All scenarios use SLOW_BIT=4, FAST_BIT=2, PWM_FULL=8, PWM_MIN=1, PWM_MAX=7, BREATH_DIV=1, ACT_STRETCH=10, LED_ACTIVE_LOW=1, CH_COUNT=4.
- Reset hold then release, all modes ON -> led_out=4'b1111 during reset; led_out=4'b0000 on the 1st cycle after release.
- ch0 SLOW, ch1 FAST -> ch0 toggles every 16 cycles and ch1 every 4 cycles; led_out[1:0] matches ~{fast_phase,slow_phase}.
- ch2 BREATH over 2*6*8 cycles -> lit count per 8-cycle period runs 1,2,..7,6,..1. Duty never hits 0 or 8.
- ch3 ACT_ONLY with a single 1-cycle activity pulse at cycle T -> lit (led_out[3]=0) from T+2 through T+11, dark at T+12. A second pulse at T+9 extends lit to T+20.
- ch0 ON_ACT, activity held high for 20 cycles -> follows fast phase while high and for 10 cycles after, then steady lit.
- lamp_test=1 with all modes OFF -> led_out=4'b0000 after 1 cycle. Asserting sys_reset_n=0 mid-test -> led_out=4'b1111 asynchronously.
